// File: rtl/srff_bank.sv
// srff_bank: a bank of clocked SR storage elements.
// Each channel has an optional s/r synchroniser and a defined S=R=1 policy.
// Conflicts are recorded as a sticky per-channel flag and a saturating count.

// One SR channel: next-state rule, q/qbar/chg registers, and a conflict strobe.
module srff_lane #(
  parameter int   CONFLICT = 1,
  parameter logic INIT_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ss,
  input  logic rs,
  input  logic en,
  output logic q,
  output logic qbar,
  output logic chg,
  output logic cf
);
  logic q_q, q_d, qbar_q, qbar_d, chg_q, chg_d;

  // Next state from the synchronised requests; S=R=1 resolved by CONFLICT.
  always_comb begin
    q_d = q_q;
    if (en) begin
      unique case ({ss, rs})
        2'b10:   q_d = 1'b1;
        2'b01:   q_d = 1'b0;
        2'b11: begin
          case (CONFLICT)
            1:       q_d = 1'b1;
            2:       q_d = 1'b0;
            3:       q_d = ~q_q;
            default: q_d = q_q;
          endcase
        end
        default: q_d = q_q;
      endcase
    end
    qbar_d = ~q_d;
    chg_d  = q_d ^ q_q;
    cf     = en & ss & rs;
  end

  // q and qbar are separate flops so qbar is glitch-free and always ~q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= INIT_BIT;
      qbar_q <= ~INIT_BIT;
      chg_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      qbar_q <= qbar_d;
      chg_q  <= chg_d;
    end
  end

  assign q    = q_q;
  assign qbar = qbar_q;
  assign chg  = chg_q;
endmodule

module srff_bank #(
  parameter int               WIDTH       = 4,
  parameter int               SYNC_STAGES = 2,
  parameter int               CONFLICT    = 1,
  parameter logic [WIDTH-1:0] INIT        = '0,
  parameter int               CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic [WIDTH-1:0] chg,
  output logic [WIDTH-1:0] conflict,
  output logic [CNT_W-1:0] conf_cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] ss, rs, cf;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign ss = s;
      assign rs = r;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][WIDTH-1:0] s_sync_q, s_sync_d, r_sync_q, r_sync_d;

      // Shift chain: stage 0 samples the raw inputs, last stage feeds the lanes.
      always_comb begin
        s_sync_d[0] = s;
        r_sync_d[0] = r;
        for (int k = 1; k < SYNC_STAGES; k++) begin
          s_sync_d[k] = s_sync_q[k-1];
          r_sync_d[k] = r_sync_q[k-1];
        end
      end

      // Synchroniser flops; shift regardless of en, dropped on reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s_sync_q <= '0;
          r_sync_q <= '0;
        end else begin
          s_sync_q <= s_sync_d;
          r_sync_q <= r_sync_d;
        end
      end

      assign ss = s_sync_q[SYNC_STAGES-1];
      assign rs = r_sync_q[SYNC_STAGES-1];
    end
  endgenerate

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      srff_lane #(.CONFLICT(CONFLICT), .INIT_BIT(INIT[i])) u_lane (
        .clk  (clk),
        .rst_n(rst_n),
        .ss   (ss[i]),
        .rs   (rs[i]),
        .en   (en),
        .q    (q[i]),
        .qbar (qbar[i]),
        .chg  (chg[i]),
        .cf   (cf[i])
      );
    end
  endgenerate

  logic [WIDTH-1:0] conflict_q, conflict_d;
  logic [CNT_W-1:0] conf_cnt_q, conf_cnt_d;

  // Sticky flags and saturating cycle count; clr beats a same-cycle conflict.
  always_comb begin
    conflict_d = conflict_q | cf;
    conf_cnt_d = conf_cnt_q;
    if (|cf && conf_cnt_q != CNT_MAX) conf_cnt_d = conf_cnt_q + CNT_W'(1);
    if (clr) begin
      conflict_d = '0;
      conf_cnt_d = '0;
    end
  end

  // Conflict bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_q <= '0;
      conf_cnt_q <= '0;
    end else begin
      conflict_q <= conflict_d;
      conf_cnt_q <= conf_cnt_d;
    end
  end

  assign conflict = conflict_q;
  assign conf_cnt = conf_cnt_q;
endmodule

// File: tb/tb_srff_bank.sv
// Bench for srff_bank: four instances share stimulus (sync 2/set-wins, and
// sync 0 with hold, reset-wins, toggle). A reference model pushes expected
// outputs per edge into queues; a monitor pops and compares after each edge.
module tb_srff_bank;
  localparam int NI = 4;
  localparam int SYNC_P[NI] = '{2, 0, 0, 0};
  localparam int POL_P[NI]  = '{1, 0, 2, 3};

  typedef struct packed {
    logic [3:0] q, qb, chg, cf, cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [3:0] s = '0, r = '0;
  logic en = 1'b1, clr = 1'b0;

  logic [3:0] q_o[NI], qb_o[NI], chg_o[NI], cf_o[NI], cnt_o[NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    srff_bank #(.WIDTH(4), .SYNC_STAGES(SYNC_P[g]), .CONFLICT(POL_P[g]),
                .INIT(4'b0000), .CNT_W(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .s(s), .r(r), .en(en), .clr(clr),
      .q(q_o[g]), .qbar(qb_o[g]), .chg(chg_o[g]), .conflict(cf_o[g]),
      .conf_cnt(cnt_o[g]));
  end

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  exp_t expq[NI][$];

  // Reference model state: stored q, sticky flags, count, and input history.
  logic [3:0] mq[NI], mcf[NI];
  int         mcnt[NI];
  logic [3:0] hs[4], hr[4];   // hs[d] = s sampled d edges ago (d=0: this edge)

  function automatic void chk(string nm, int k, logic [3:0] act, logic [3:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s inst%0d t=%0t got=%b want=%b", nm, k, $time, act, expv);
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < NI; k++) begin
      mq[k] = '0; mcf[k] = '0; mcnt[k] = 0;
    end
    for (int d = 0; d < 4; d++) begin
      hs[d] = '0; hr[d] = '0;
    end
  endfunction

  // Predict the outputs after the next rising edge for the current inputs.
  function automatic void model_edge();
    for (int d = 3; d > 0; d--) begin
      hs[d] = hs[d-1]; hr[d] = hr[d-1];
    end
    hs[0] = s; hr[0] = r;
    for (int k = 0; k < NI; k++) begin
      logic [3:0] ssv, rsv, nq, both;
      exp_t e;
      ssv  = hs[SYNC_P[k]];
      rsv  = hr[SYNC_P[k]];
      both = ssv & rsv;
      nq   = mq[k];
      if (en) begin
        for (int i = 0; i < 4; i++) begin
          if (ssv[i] && !rsv[i])      nq[i] = 1'b1;
          else if (!ssv[i] && rsv[i]) nq[i] = 1'b0;
          else if (ssv[i] && rsv[i]) begin
            if (POL_P[k] == 1)      nq[i] = 1'b1;
            else if (POL_P[k] == 2) nq[i] = 1'b0;
            else if (POL_P[k] == 3) nq[i] = ~mq[k][i];
          end
        end
        mcf[k] = mcf[k] | both;
        if (both != 0 && mcnt[k] < 15) mcnt[k]++;
      end
      if (clr) begin
        mcf[k] = '0; mcnt[k] = 0;
      end
      e.chg = nq ^ mq[k];
      mq[k] = nq;
      e.q = nq; e.qb = ~nq; e.cf = mcf[k]; e.cnt = 4'(mcnt[k]);
      expq[k].push_back(e);
    end
  endfunction

  task automatic step(input logic [3:0] sv, input logic [3:0] rv,
                      input logic ev, input logic cv);
    @(negedge clk);
    s = sv; r = rv; en = ev; clr = cv;
    model_edge();
  endtask

  task automatic check_reset_vals();
    for (int k = 0; k < NI; k++) begin
      chk("rst_q",    k, q_o[k],   4'b0000);
      chk("rst_qbar", k, qb_o[k],  4'b1111);
      chk("rst_chg",  k, chg_o[k], 4'b0000);
      chk("rst_conf", k, cf_o[k],  4'b0000);
      chk("rst_cnt",  k, cnt_o[k], 4'b0000);
    end
  endtask

  // Asynchronous reset taken mid-cycle, away from any edge.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_vals();
    s = '0; r = '0; en = 1'b1; clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every edge with an expectation pending, compare all instances.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && expq[0].size() > 0) begin
        for (int k = 0; k < NI; k++) begin
          exp_t e;
          e = expq[k].pop_front();
          chk("q",        k, q_o[k],   e.q);
          chk("qbar",     k, qb_o[k],  e.qb);
          chk("chg",      k, chg_o[k], e.chg);
          chk("conflict", k, cf_o[k],  e.cf);
          chk("conf_cnt", k, cnt_o[k], e.cnt);
        end
      end
    end
  end

  initial begin
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // idle
    repeat (10) step(4'b0000, 4'b0000, 1'b1, 1'b0);
    // latency: one-cycle set, then one-cycle reset
    step(4'b0001, 4'b0000, 1'b1, 1'b0);
    repeat (4) step(4'b0000, 4'b0000, 1'b1, 1'b0);
    step(4'b0000, 4'b0001, 1'b1, 1'b0);
    repeat (4) step(4'b0000, 4'b0000, 1'b1, 1'b0);
    // conflict on channel 1 for 3 cycles, then clr
    repeat (3) step(4'b0010, 4'b0010, 1'b1, 1'b0);
    repeat (3) step(4'b0000, 4'b0000, 1'b1, 1'b0);
    step(4'b0000, 4'b0000, 1'b1, 1'b1);
    repeat (2) step(4'b0000, 4'b0000, 1'b1, 1'b0);
    // policy sweep on channel 0 (clear q first)
    step(4'b0000, 4'b1111, 1'b1, 1'b0);
    repeat (3) step(4'b0000, 4'b0000, 1'b1, 1'b1);
    repeat (4) step(4'b0001, 4'b0001, 1'b1, 1'b0);
    repeat (3) step(4'b0000, 4'b0000, 1'b1, 1'b0);
    // saturation, then clr in the same cycle as a conflict
    repeat (20) step(4'b0100, 4'b0100, 1'b1, 1'b0);
    step(4'b0100, 4'b0100, 1'b1, 1'b1);
    repeat (3) step(4'b0000, 4'b0000, 1'b1, 1'b1);
    // en gating
    step(4'b0000, 4'b1111, 1'b1, 1'b0);
    repeat (3) step(4'b0000, 4'b0000, 1'b1, 1'b0);
    repeat (4) step(4'b1111, 4'b0000, 1'b0, 1'b0);
    repeat (3) step(4'b1111, 4'b0000, 1'b1, 1'b0);
    // conflicts under en=0 must not count
    repeat (4) step(4'b1111, 4'b1111, 1'b0, 1'b0);
    // mid-op reset with synchroniser data in flight
    step(4'b0000, 4'b1111, 1'b1, 1'b0);
    step(4'b1010, 4'b0000, 1'b1, 1'b0);
    do_reset();
    repeat (4) step(4'b0000, 4'b0000, 1'b1, 1'b0);

    // randomized traffic with an occasional reset
    for (int n = 0; n < 400; n++) begin
      step(4'($urandom), 4'($urandom), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 15) == 0));
      if (n == 200) do_reset();
    end

    repeat (3) @(negedge clk);
    total++;
    if (expq[0].size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", expq[0].size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
